// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - op codes, FSM states and constants shared by the ALU arbiter.
package alu_arb_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MOD = 3'b111;

    // Returned instead of running the ALU when MOD divisor is zero.
    localparam logic [63:0] MOD_ZERO_RESULT = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLR  = 2'd1,
        S_EXEC = 2'd2,
        S_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/alu_arb_if.sv
// rtl/alu_arb_if.sv - requester-side request/response bus of the ALU arbiter.
interface alu_arb_if #(
    parameter int N = 4,
    parameter int W = 32
);
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N*3-1:0] req_op;
    logic [N-1:0]   resp_valid;
    logic [W-1:0]   resp_data;
    logic           resp_err;

    modport master (
        output req_valid, req_a, req_b, req_op,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/alu_32.sv
// rtl/alu_32.sv - 32-bit ALU: single-cycle logic/arith ops, bit-serial MOD restarted by reset.
module alu_32 (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  Alu_Op,
    output logic [31:0] res
);

    logic [31:0] rem;
    logic [5:0]  bit_cnt;
    logic [32:0] sh;
    logic [32:0] nxt;

    // Restoring remainder, one dividend bit per cycle, 32 cycles after reset.
    always_comb begin
        sh  = {rem, A[5'd31 - bit_cnt[4:0]]};
        nxt = (sh >= {1'b0, B}) ? sh - {1'b0, B} : sh;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem     <= '0;
            bit_cnt <= '0;
        end else if (bit_cnt != 6'd32) begin
            rem     <= nxt[31:0];
            bit_cnt <= bit_cnt + 6'd1;
        end
    end

    always_comb begin
        case (Alu_Op)
            3'b000:  res = A & B;
            3'b001:  res = A | B;
            3'b010:  res = A ^ B;
            3'b011:  res = ~(A | B);
            3'b100:  res = {31'd0, $signed(A) < $signed(B)};
            3'b101:  res = A + B;
            3'b110:  res = A - B;
            default: res = rem;
        endcase
    end

endmodule

// File: rtl/alu_arb_picker.sv
// rtl/alu_arb_picker.sv - combinational grant picker; ALU_ARB_RR_EN selects round-robin over fixed priority.
module alu_arb_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_valid,
`ifdef ALU_ARB_RR_EN
    input  logic [IW-1:0] rr_ptr,
`endif
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    int i;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        i     = 0;
        for (int k = 0; k < N; k++) begin
`ifdef ALU_ARB_RR_EN
            i = (int'(rr_ptr) + k) % N;
`else
            i = k;
`endif
            if (!any && req_valid[i]) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                idx      = IW'(i);
            end
        end
    end

endmodule

// File: rtl/alu_arb_ctrl.sv
// rtl/alu_arb_ctrl.sv - shares one alu_32 among N requesters; ALU_ARB_RR_EN enables round-robin.
module alu_arb_ctrl
    import alu_arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int W         = 32,
    parameter int LAT_BASIC = 1,
    parameter int LAT_MOD   = 40
) (
    input  logic         clock,
    input  logic         reset,
    alu_arb_if.slave     bus,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_op,
    output logic         alu_clr,
    input  logic [W-1:0] alu_res,
    output logic         busy
);

    localparam int IW   = $clog2(N);
    localparam int LMAX = (LAT_MOD > LAT_BASIC) ? LAT_MOD : LAT_BASIC;
    localparam int CW   = $clog2(LMAX) + 1;

    generate
        if (N < 2 || N > 8) begin : g_bad_n
            $error("alu_arb_ctrl: N must be in 2..8");
        end
    endgenerate

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [IW-1:0] id_q, gnt_idx;
    logic [2:0]    op_q, sel_op;
    logic [W-1:0]  a_q, b_q, sel_a, sel_b;
    logic [N-1:0]  gnt;
    logic          gnt_any;
    logic          sel_mod_zero;

`ifdef ALU_ARB_RR_EN
    logic [IW-1:0] rr_ptr;
`endif

    alu_arb_picker #(.N(N), .IW(IW)) u_picker (
        .req_valid (bus.req_valid),
`ifdef ALU_ARB_RR_EN
        .rr_ptr    (rr_ptr),
`endif
        .grant     (gnt),
        .idx       (gnt_idx),
        .any       (gnt_any)
    );

    assign sel_a        = bus.req_a[int'(gnt_idx)*W +: W];
    assign sel_b        = bus.req_b[int'(gnt_idx)*W +: W];
    assign sel_op       = bus.req_op[int'(gnt_idx)*3 +: 3];
    assign sel_mod_zero = (sel_op == OP_MOD) && (sel_b == '0);

    always_comb begin
        state_nxt      = state;
        bus.req_ready  = '0;
        bus.resp_valid = '0;
        alu_clr        = 1'b0;
        busy           = (state != S_IDLE);
        alu_a          = busy ? a_q  : '0;
        alu_b          = busy ? b_q  : '0;
        alu_op         = busy ? op_q : 3'b000;
        case (state)
            S_IDLE: if (gnt_any) begin
                bus.req_ready = gnt;
                if (sel_op != OP_MOD) state_nxt = S_EXEC;
                else if (sel_mod_zero) state_nxt = S_RESP;
                else state_nxt = S_CLR;
            end
            S_CLR: begin
                alu_clr   = 1'b1;
                state_nxt = S_EXEC;
            end
            S_EXEC: if (cnt == '0) state_nxt = S_RESP;
            S_RESP: begin
                bus.resp_valid[id_q] = 1'b1;
                state_nxt            = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            id_q          <= '0;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            bus.resp_data <= '0;
            bus.resp_err  <= 1'b0;
`ifdef ALU_ARB_RR_EN
            rr_ptr        <= '0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: if (gnt_any) begin
                    id_q <= gnt_idx;
                    op_q <= sel_op;
                    a_q  <= sel_a;
                    b_q  <= sel_b;
                    if (sel_mod_zero) begin
                        bus.resp_data <= MOD_ZERO_RESULT[W-1:0];
                        bus.resp_err  <= 1'b1;
                    end else if (sel_op != OP_MOD) begin
                        cnt <= CW'(LAT_BASIC - 1);
                    end
                end
                S_CLR: cnt <= CW'(LAT_MOD - 1);
                S_EXEC: begin
                    if (cnt == '0) begin
                        bus.resp_data <= alu_res;
                        bus.resp_err  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RESP: begin
`ifdef ALU_ARB_RR_EN
                    rr_ptr <= (id_q == IW'(N - 1)) ? '0 : id_q + 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arb_ctrl.sv
// tb/tb_alu_arb_ctrl.sv - directed self-checking bench for alu_arb_ctrl driving a real alu_32.
module tb_alu_arb_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] alu_a, alu_b, alu_res;
    logic [2:0]  alu_op;
    logic        alu_clr, busy;

    int n_assert = 0;
    int n_fail   = 0;

    alu_arb_if #(.N(4), .W(32)) bus ();

    alu_arb_ctrl #(.N(4), .W(32), .LAT_BASIC(1), .LAT_MOD(40)) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_op  (alu_op),
        .alu_clr (alu_clr),
        .alu_res (alu_res),
        .busy    (busy)
    );

    alu_32 u_alu (
        .clk    (clock),
        .reset  (alu_clr),
        .A      (alu_a),
        .B      (alu_b),
        .Alu_Op (alu_op),
        .res    (alu_res)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic run(input int r, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_d, input logic exp_e, input int exp_lat, input string tag);
        int   cyc, nclr, clr_at, unstable, idle_seen;
        logic seen;
        bus.req_op[r*3 +: 3]  = op;
        bus.req_a[r*32 +: 32] = a;
        bus.req_b[r*32 +: 32] = b;
        bus.req_valid[r]      = 1'b1;
        #1;
        chk({tag, " ready"}, 32'(bus.req_ready), 32'(1 << r));
        cyc = 0; nclr = 0; clr_at = -1; unstable = 0; idle_seen = 0; seen = 1'b0;
        while (!seen && cyc < 100) begin
            tick();
            cyc++;
            bus.req_valid[r] = 1'b0;
            if (alu_clr) begin nclr++; clr_at = cyc; end
            if (!busy) idle_seen++;
            else if (alu_a !== a || alu_b !== b || alu_op !== op) unstable++;
            if (bus.resp_valid != 4'b0) seen = 1'b1;
        end
        chk({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, " resp_valid"}, 32'(bus.resp_valid), 32'(1 << r));
        chk({tag, " resp_data"}, bus.resp_data, exp_d);
        chk({tag, " resp_err"}, 32'(bus.resp_err), 32'(exp_e));
        chk({tag, " ready_in_resp"}, 32'(bus.req_ready), 32'd0);
        chk({tag, " clr_count"}, 32'(nclr), (op == 3'b111 && b != 0) ? 32'd1 : 32'd0);
        if (nclr == 1) chk({tag, " clr_cycle"}, 32'(clr_at), 32'd1);
        chk({tag, " alu_stable"}, 32'(unstable), 32'd0);
        chk({tag, " busy_held"}, 32'(idle_seen), 32'd0);
        tick();
    endtask

    initial begin
        int          g_cyc;
        logic [3:0]  g;
        int          exp_g;

        reset         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        #1;
        chk("reset ready", 32'(bus.req_ready), 32'd0);
        chk("reset resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("reset resp_data", bus.resp_data, 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset alu_clr", 32'(alu_clr), 32'd0);
        chk("reset alu_a", alu_a, 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        tick();

        run(0, 3'b000, 32'h0, 32'hFFFF_FFFF, 32'h0,         1'b0, 2, "and");
        run(0, 3'b011, 32'h0, 32'hFFFF_FFFF, 32'h0,         1'b0, 2, "nor");
        run(0, 3'b010, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2, "xor");
        run(1, 3'b101, 32'd3, 32'd3,         32'd6,         1'b0, 2, "add");
        run(2, 3'b110, 32'd5, 32'd3,         32'd2,         1'b0, 2, "sub");
        run(3, 3'b100, 32'd1, 32'd3,         32'd1,         1'b0, 2, "slt");
        run(0, 3'b111, 32'd13, 32'd5,        32'd3,         1'b0, 42, "mod");
        run(0, 3'b111, 32'd13, 32'd0,        32'hFFFF_FFFF, 1'b1, 1, "mod0");

        // All four requesters held valid; each adds its own index to zero.
        for (int i = 0; i < 4; i++) begin
            bus.req_op[i*3 +: 3]  = 3'b101;
            bus.req_a[i*32 +: 32] = 32'(i);
            bus.req_b[i*32 +: 32] = 32'd0;
        end
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
`ifdef ALU_ARB_RR_EN
            exp_g = k % 4;
`else
            exp_g = 0;
`endif
            #1;
            g = bus.req_ready;
            chk($sformatf("arb grant %0d", k), 32'(g), 32'(1 << exp_g));
            g_cyc = 0;
            do begin
                tick();
                g_cyc++;
            end while (bus.resp_valid == 4'b0 && g_cyc < 10);
            chk($sformatf("arb resp_valid %0d", k), 32'(bus.resp_valid), 32'(1 << exp_g));
            chk($sformatf("arb resp_data %0d", k), bus.resp_data, 32'(exp_g));
            tick();
        end
        bus.req_valid = '0;
        tick();

        // Reset lands in cycle 10 of a MOD (inside EXEC).
        bus.req_op[2:0] = 3'b111;
        bus.req_a[31:0] = 32'd13;
        bus.req_b[31:0] = 32'd5;
        bus.req_valid   = 4'b0001;
        #1;
        chk("rst ready", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = '0;
        repeat (9) tick();
        chk("rst busy_before", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst alu_a", alu_a, 32'd0);
        chk("rst alu_b", alu_b, 32'd0);
        chk("rst alu_op", 32'(alu_op), 32'd0);
        chk("rst alu_clr", 32'(alu_clr), 32'd0);
        chk("rst resp_data", bus.resp_data, 32'd0);
        chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("rst no_resp", 32'(bus.resp_valid), 32'd0);
        end
        reset = 1'b1;
        tick();
        run(0, 3'b111, 32'd13, 32'd5, 32'd3, 1'b0, 42, "mod_reissue");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
